// File: rtl/fp_mul_pkg.sv
// Shared types and sizing helpers for the FP multiplier datapath.
package fp_mul_pkg;

    // Single-precision mantissa width, including the hidden bit.
    localparam int MANT_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Number of partial-row iterations for one product.
    function automatic int mul_niter(input int width, input int bpc);
        return width / bpc;
    endfunction

    // Counter width with one bit of headroom above the largest index.
    function automatic int mul_cnt_w(input int width, input int bpc);
        return $clog2(width / bpc) + 1;
    endfunction

endpackage

// File: rtl/mul_partial_row.sv
// One WIDTH x BPC partial product: the multiplicand ANDed with each of the
// BPC multiplier bits, shifted into place and summed.
module mul_partial_row #(
    parameter int WIDTH = 24,
    parameter int BPC   = 4
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [BPC-1:0]       b_chunk,
    output logic [WIDTH+BPC-1:0] row
);

    logic [WIDTH+BPC-1:0] a_ext;

    assign a_ext = (WIDTH + BPC)'(a);

    // Sum the BPC AND-shifted copies of the multiplicand.
    always_comb begin
        row = '0;
        for (int i = 0; i < BPC; i++) begin
            if (b_chunk[i]) begin
                row = row + (a_ext << i);
            end
        end
    end

endmodule

// File: rtl/seq_mantissa_multiplier.sv
// Iterative unsigned WIDTH x WIDTH multiplier, BPC multiplier bits per cycle,
// with a pass-through tag so the FP wrapper can re-associate sign/exponent.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE, and
// out_p/out_tag stay frozen until the consumer takes them with out_ready.
// Accept and retire never coincide, and operands offered while busy are
// ignored rather than queued.
module seq_mantissa_multiplier
    import fp_mul_pkg::*;
#(
    parameter int WIDTH = MANT_W,
    parameter int BPC   = 4,
    parameter int TAG_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output mul_state_t         dbg_state
);

    localparam int NITER  = mul_niter(WIDTH, BPC);
    localparam int CNT_W  = mul_cnt_w(WIDTH, BPC);
    localparam int PROD_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NITER - 1);

    if (WIDTH % BPC != 0) begin : g_bad_bpc
        $error("seq_mantissa_multiplier: WIDTH must be a multiple of BPC");
    end

    mul_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic [TAG_W-1:0]      tag_q;
    logic [PROD_W-1:0]     acc;
    logic [BPC-1:0]        b_chunk;
    logic [WIDTH+BPC-1:0]  row;
    logic [PROD_W-1:0]     row_shifted;
    logic [PROD_W-1:0]     acc_next;

    // Multiplier slice for the current iteration, lowest bits first.
    assign b_chunk = b_q[int'(cnt) * BPC +: BPC];

    mul_partial_row #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_row (
        .a       (a_q),
        .b_chunk (b_chunk),
        .row     (row)
    );

    // Align the partial row to its weight and add it in; the running sum
    // never exceeds a*b, so PROD_W bits cannot overflow.
    assign row_shifted = PROD_W'(row) << (int'(cnt) * BPC);
    assign acc_next    = acc + row_shifted;

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;

    // Control FSM, operand capture, accumulation and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            acc       <= '0;
            out_p     <= '0;
            out_tag   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        tag_q <= in_tag;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    // Fixed latency: no early exit on zero multiplier bits.
                    if (cnt == LAST_CNT) begin
                        out_p     <= acc_next;
                        out_tag   <= tag_q;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
